// File: rtl/motor_ctrl_pkg.sv
// Shared widths, FSM state type and duty saturation helper for the motor speed controller.
package motor_ctrl_pkg;

    localparam int RPM_W     = 10;
    localparam int ERR_W     = 11;
    localparam int DERIV_W   = 12;
    localparam int INT_W     = 16;
    localparam int DUTY_W    = 8;
    localparam int GAIN_W    = 16;
    localparam int FRAC_BITS = 8;

    // Shared multiplier operands are one bit wider than the gains so an
    // unsigned Q8.8 gain can be carried as a non-negative signed value.
    localparam int MUL_W  = GAIN_W + 1;
    localparam int PROD_W = 2 * MUL_W;
    localparam int SUM_W  = PROD_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERR,
        ST_MUL_P,
        ST_MUL_I,
        ST_MUL_D,
        ST_SUM,
        ST_SAT
    } pid_state_t;

    // Clamp the scaled PID sum into the 0..255 duty range.
    function automatic logic [DUTY_W-1:0] saturate_duty(input logic signed [SUM_W-1:0] v);
        if (v < 36'sd0) begin
            return '0;
        end else if (v > 36'sd255) begin
            return 8'd255;
        end else begin
            return v[DUTY_W-1:0];
        end
    endfunction

endpackage

// File: rtl/motor_pid_controller_pwm.sv
// PWM generator: prescaled 8-bit counter with duty latched only at period boundaries.
module pwm_generator #(
    parameter int PWM_PRESCALE = 20
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       enable_in,
    input  logic [7:0] duty_in,
    output logic       pwm_out
);

    localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_PRESCALE - 1);

    logic [PRE_W-1:0] prescale_reg;
    logic [7:0]       pwm_cnt_reg;
    logic [7:0]       duty_latched_reg;

    // Prescaler, period counter and boundary-latched duty; held cleared while disabled.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            prescale_reg     <= '0;
            pwm_cnt_reg      <= '0;
            duty_latched_reg <= '0;
        end else if (!enable_in) begin
            prescale_reg     <= '0;
            pwm_cnt_reg      <= '0;
            duty_latched_reg <= '0;
        end else if (prescale_reg == PRE_LAST) begin
            prescale_reg <= '0;
            pwm_cnt_reg  <= pwm_cnt_reg + 8'd1;
            if (pwm_cnt_reg == 8'd255) begin
                duty_latched_reg <= duty_in;
            end
        end else begin
            prescale_reg <= prescale_reg + 1'b1;
        end
    end

    // Enable gates the output combinationally so the motor stops without waiting a clock.
    assign pwm_out = enable_in && (pwm_cnt_reg < duty_latched_reg);

endmodule

// File: rtl/motor_pid_controller.sv
// Closed-loop PID speed controller: one shared multiplier sequenced by a 7-state FSM, driving a PWM.
module motor_pid_controller
    import motor_ctrl_pkg::*;
#(
    parameter logic [15:0] KP             = 16'd256,
    parameter logic [15:0] KI             = 16'd0,
    parameter logic [15:0] KD             = 16'd0,
    parameter logic [15:0] INTEGRAL_LIMIT = 16'd8000,
    parameter int          PWM_PRESCALE   = 20
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              enable_in,
    input  logic              sample_valid_in,
    input  logic [RPM_W-1:0]  target_rpm_in,
    input  logic [RPM_W-1:0]  actual_rpm_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic              update_out,
    output logic              busy_out,
    output logic              sample_dropped_out,
    output logic              pwm_out
);

    localparam logic signed [INT_W:0] LIM_POS = $signed({1'b0, INTEGRAL_LIMIT});
    localparam logic signed [INT_W:0] LIM_NEG = -LIM_POS;

    pid_state_t state_reg, state_next;
    logic       busy_reg, busy_next;
    logic       update_reg, update_next;
    logic       dropped_reg, dropped_next;

    logic [RPM_W-1:0]          target_reg, actual_reg;
    logic signed [ERR_W-1:0]   err_reg, err_prev_reg;
    logic signed [DERIV_W-1:0] deriv_reg;
    logic signed [INT_W-1:0]   integral_reg;
    logic signed [PROD_W-1:0]  prod_p_reg, prod_i_reg, prod_d_reg;
    logic signed [SUM_W-1:0]   sum_reg;
    logic [DUTY_W-1:0]         duty_reg;

    logic signed [ERR_W-1:0]   err_calc;
    logic signed [DERIV_W-1:0] deriv_calc;
    logic signed [INT_W:0]     int_sum;
    logic signed [INT_W-1:0]   int_next;
    logic signed [MUL_W-1:0]   mul_a, mul_b;
    logic signed [PROD_W-1:0]  mul_prod;
    logic signed [SUM_W-1:0]   sum_full;

    // FSM state register.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state sequencing plus the busy/update/dropped strobes; disable overrides everything.
    always_comb begin
        state_next   = state_reg;
        busy_next    = 1'b0;
        update_next  = 1'b0;
        dropped_next = 1'b0;
        case (state_reg)
            ST_IDLE:  if (sample_valid_in) state_next = ST_ERR;
            ST_ERR:   state_next = ST_MUL_P;
            ST_MUL_P: state_next = ST_MUL_I;
            ST_MUL_I: state_next = ST_MUL_D;
            ST_MUL_D: state_next = ST_SUM;
            ST_SUM:   state_next = ST_SAT;
            ST_SAT:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (!enable_in) begin
            state_next = ST_IDLE;
        end
        busy_next    = (state_next != ST_IDLE);
        update_next  = enable_in && (state_reg == ST_SAT);
        dropped_next = enable_in && sample_valid_in && (state_reg != ST_IDLE);
    end

    // Registered status outputs.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            busy_reg    <= 1'b0;
            update_reg  <= 1'b0;
            dropped_reg <= 1'b0;
        end else begin
            busy_reg    <= busy_next;
            update_reg  <= update_next;
            dropped_reg <= dropped_next;
        end
    end

    // Error, derivative and clamped integral candidates computed from the latched sample.
    always_comb begin
        err_calc   = $signed({1'b0, target_reg}) - $signed({1'b0, actual_reg});
        deriv_calc = $signed({err_calc[ERR_W-1], err_calc})
                   - $signed({err_prev_reg[ERR_W-1], err_prev_reg});
        int_sum    = $signed({integral_reg[INT_W-1], integral_reg})
                   + $signed({{(INT_W + 1 - ERR_W){err_calc[ERR_W-1]}}, err_calc});
        int_next   = int_sum[INT_W-1:0];
        if (int_sum > LIM_POS) begin
            int_next = LIM_POS[INT_W-1:0];
        end else if (int_sum < LIM_NEG) begin
            int_next = LIM_NEG[INT_W-1:0];
        end
    end

    // Shared multiplier operand selection: gain times the term belonging to the current state.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_reg)
            ST_MUL_P: begin
                mul_a = $signed({1'b0, KP});
                mul_b = $signed({{(MUL_W - ERR_W){err_reg[ERR_W-1]}}, err_reg});
            end
            ST_MUL_I: begin
                mul_a = $signed({1'b0, KI});
                mul_b = $signed({integral_reg[INT_W-1], integral_reg});
            end
            ST_MUL_D: begin
                mul_a = $signed({1'b0, KD});
                mul_b = $signed({{(MUL_W - DERIV_W){deriv_reg[DERIV_W-1]}}, deriv_reg});
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
        mul_prod = mul_a * mul_b;
        sum_full = $signed({{2{prod_p_reg[PROD_W-1]}}, prod_p_reg})
                 + $signed({{2{prod_i_reg[PROD_W-1]}}, prod_i_reg})
                 + $signed({{2{prod_d_reg[PROD_W-1]}}, prod_d_reg});
    end

    // PID datapath: each FSM state updates exactly the registers it owns.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            target_reg   <= '0;
            actual_reg   <= '0;
            err_reg      <= '0;
            err_prev_reg <= '0;
            deriv_reg    <= '0;
            integral_reg <= '0;
            prod_p_reg   <= '0;
            prod_i_reg   <= '0;
            prod_d_reg   <= '0;
            sum_reg      <= '0;
            duty_reg     <= '0;
        end else if (!enable_in) begin
            integral_reg <= '0;
            err_prev_reg <= '0;
            duty_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (sample_valid_in) begin
                        target_reg <= target_rpm_in;
                        actual_reg <= actual_rpm_in;
                    end
                end
                ST_ERR: begin
                    err_reg      <= err_calc;
                    deriv_reg    <= deriv_calc;
                    integral_reg <= int_next;
                    err_prev_reg <= err_calc;
                end
                ST_MUL_P: prod_p_reg <= mul_prod;
                ST_MUL_I: prod_i_reg <= mul_prod;
                ST_MUL_D: prod_d_reg <= mul_prod;
                ST_SUM:   sum_reg    <= sum_full >>> FRAC_BITS;
                ST_SAT:   duty_reg   <= saturate_duty(sum_reg);
                default:  ;
            endcase
        end
    end

    assign duty_out           = duty_reg;
    assign update_out         = update_reg;
    assign busy_out           = busy_reg;
    assign sample_dropped_out = dropped_reg;

    pwm_generator #(
        .PWM_PRESCALE(PWM_PRESCALE)
    ) u_pwm (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .enable_in (enable_in),
        .duty_in   (duty_reg),
        .pwm_out   (pwm_out)
    );

endmodule

// File: tb/tb_motor_pid_controller.sv
// Scenario bench for motor_pid_controller: four gain/prescale configurations share one stimulus bus.
module tb_motor_pid_controller;

    localparam int P = 0;  // KP=1.0
    localparam int I = 1;  // KI=0.5
    localparam int D = 2;  // KD=1.0
    localparam int W = 3;  // KP=1.0, PWM_PRESCALE=1

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       valid;
    logic [9:0] tgt;
    logic [9:0] act;

    logic [7:0] duty [4];
    logic       upd  [4];
    logic       busy [4];
    logic       drop [4];
    logic       pwm  [4];

    int          errors = 0;
    int          checks = 0;
    int unsigned tb_cyc = 0;
    logic [7:0]  exp_q[$];

    always #4 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    motor_pid_controller #(.KP(16'd256), .KI(16'd0), .KD(16'd0), .INTEGRAL_LIMIT(16'd8000), .PWM_PRESCALE(20)) u_p (
        .clk_in(clk), .reset_in(rst), .enable_in(en), .sample_valid_in(valid),
        .target_rpm_in(tgt), .actual_rpm_in(act), .duty_out(duty[P]), .update_out(upd[P]),
        .busy_out(busy[P]), .sample_dropped_out(drop[P]), .pwm_out(pwm[P]));

    motor_pid_controller #(.KP(16'd0), .KI(16'd128), .KD(16'd0), .INTEGRAL_LIMIT(16'd8000), .PWM_PRESCALE(20)) u_i (
        .clk_in(clk), .reset_in(rst), .enable_in(en), .sample_valid_in(valid),
        .target_rpm_in(tgt), .actual_rpm_in(act), .duty_out(duty[I]), .update_out(upd[I]),
        .busy_out(busy[I]), .sample_dropped_out(drop[I]), .pwm_out(pwm[I]));

    motor_pid_controller #(.KP(16'd0), .KI(16'd0), .KD(16'd256), .INTEGRAL_LIMIT(16'd8000), .PWM_PRESCALE(20)) u_d (
        .clk_in(clk), .reset_in(rst), .enable_in(en), .sample_valid_in(valid),
        .target_rpm_in(tgt), .actual_rpm_in(act), .duty_out(duty[D]), .update_out(upd[D]),
        .busy_out(busy[D]), .sample_dropped_out(drop[D]), .pwm_out(pwm[D]));

    motor_pid_controller #(.KP(16'd256), .KI(16'd0), .KD(16'd0), .INTEGRAL_LIMIT(16'd8000), .PWM_PRESCALE(1)) u_w (
        .clk_in(clk), .reset_in(rst), .enable_in(en), .sample_valid_in(valid),
        .target_rpm_in(tgt), .actual_rpm_in(act), .duty_out(duty[W]), .update_out(upd[W]),
        .busy_out(busy[W]), .sample_dropped_out(drop[W]), .pwm_out(pwm[W]));

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        en    = 1'b0;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
    endtask

    // One-cycle strobe; the expected duty is pushed at drive time when the sample should complete.
    task automatic strobe(input logic [9:0] t, input logic [9:0] a, input bit push, input logic [7:0] exp_d);
        tgt   = t;
        act   = a;
        valid = 1'b1;
        if (push) exp_q.push_back(exp_d);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_update(input int inst, output bit got);
        got = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (upd[inst] === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        checks++; if (duty[P] !== 8'd0) begin errors++; $display("FAIL reset_duty: got %0d want 0", duty[P]); end
        checks++; if (upd[P]  !== 1'b0) begin errors++; $display("FAIL reset_update: got %b want 0", upd[P]); end
        checks++; if (busy[P] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy[P]); end
        checks++; if (drop[P] !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b want 0", drop[P]); end
        checks++; if (pwm[P]  !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b want 0", pwm[P]); end
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy[P] !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy[P]); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [7:0] exp_d;
        do_reset();
        strobe(10'd300, 10'd100, 1'b1, 8'd200);
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (busy[P] !== (k <= 6)) begin errors++; $display("FAIL basic_busy c%0d: got %b want %b", k, busy[P], (k <= 6)); end
            checks++;
            if (upd[P] !== (k == 7)) begin errors++; $display("FAIL basic_update c%0d: got %b want %b", k, upd[P], (k == 7)); end
            if (k == 7) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (duty[P] !== exp_d) begin errors++; $display("FAIL basic_duty: got %0d want %0d", duty[P], exp_d); end
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        checks++; if (upd[P] !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b want 0", upd[P]); end
        $display("test_basic: target 300 actual 100 duty %0d", duty[P]);
    endtask

    task automatic test_saturation();
        bit got;
        logic [7:0] exp_d;
        strobe(10'd900, 10'd100, 1'b1, 8'd255);
        wait_update(P, got);
        exp_d = exp_q.pop_front();
        checks++;
        if (!got) begin errors++; $display("FAIL sat_high: no update, want %0d", exp_d); end
        else if (duty[P] !== exp_d) begin errors++; $display("FAIL sat_high: got %0d want %0d", duty[P], exp_d); end
        $display("test_saturation: target 900 actual 100 duty %0d", duty[P]);
        strobe(10'd100, 10'd500, 1'b1, 8'd0);
        wait_update(P, got);
        exp_d = exp_q.pop_front();
        checks++;
        if (!got) begin errors++; $display("FAIL sat_low: no update, want %0d", exp_d); end
        else if (duty[P] !== exp_d) begin errors++; $display("FAIL sat_low: got %0d want %0d", duty[P], exp_d); end
        $display("test_saturation: target 100 actual 500 duty %0d", duty[P]);
    endtask

    // Integral with KI=0.5: small steps, then clamp at +8000 verified by how fast it unwinds.
    task automatic test_integral();
        bit got;
        logic [7:0] exp_d;
        int acc;
        do_reset();
        acc = 0;
        for (int s = 0; s < 22; s++) begin
            logic [9:0] t, a;
            if (s < 3)       begin t = 10'd110;  a = 10'd100; end
            else if (s < 13) begin t = 10'd1023; a = 10'd0;   end
            else if (s < 21) begin t = 10'd0;    a = 10'd1000; end
            else             begin t = 10'd10;   a = 10'd0;   end
            acc = acc + (int'(t) - int'(a));
            if (acc > 8000) acc = 8000;
            if (acc < -8000) acc = -8000;
            exp_d = ((acc * 128) / 256 > 255) ? 8'd255 : ((acc < 0) ? 8'd0 : 8'((acc * 128) / 256));
            strobe(t, a, 1'b1, exp_d);
            wait_update(I, got);
            exp_d = exp_q.pop_front();
            checks++;
            if (!got) begin errors++; $display("FAIL integral s%0d: no update, want %0d", s, exp_d); end
            else if (duty[I] !== exp_d) begin errors++; $display("FAIL integral s%0d: got %0d want %0d", s, duty[I], exp_d); end
            $display("test_integral: step %0d err %0d duty %0d", s, int'(t) - int'(a), duty[I]);
        end
    endtask

    task automatic test_derivative();
        bit got;
        logic [7:0] exp_d;
        do_reset();
        strobe(10'd120, 10'd100, 1'b1, 8'd20);
        repeat (2) @(negedge clk);
        tgt   = 10'd500;
        act   = 10'd0;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        checks++; if (drop[D] !== 1'b1) begin errors++; $display("FAIL dropped_pulse: got %b want 1", drop[D]); end
        @(negedge clk);
        checks++; if (drop[D] !== 1'b0) begin errors++; $display("FAIL dropped_single: got %b want 0", drop[D]); end
        wait_update(D, got);
        exp_d = exp_q.pop_front();
        checks++;
        if (!got) begin errors++; $display("FAIL deriv_first: no update, want %0d", exp_d); end
        else if (duty[D] !== exp_d) begin errors++; $display("FAIL deriv_first: got %0d want %0d", duty[D], exp_d); end
        $display("test_derivative: err 20 duty %0d", duty[D]);
        @(negedge clk);
        checks++; if (busy[D] !== 1'b0) begin errors++; $display("FAIL dropped_not_queued: busy %b want 0", busy[D]); end
        strobe(10'd150, 10'd100, 1'b1, 8'd30);
        wait_update(D, got);
        exp_d = exp_q.pop_front();
        checks++;
        if (!got) begin errors++; $display("FAIL deriv_second: no update, want %0d", exp_d); end
        else if (duty[D] !== exp_d) begin errors++; $display("FAIL deriv_second: got %0d want %0d", duty[D], exp_d); end
        $display("test_derivative: err 50 duty %0d", duty[D]);
    endtask

    task automatic test_pwm();
        bit got;
        bit found;
        logic prev;
        logic [7:0] exp_d;
        int highs;
        int unsigned t0;
        do_reset();
        strobe(10'd64, 10'd0, 1'b1, 8'd64);
        wait_update(W, got);
        exp_d = exp_q.pop_front();
        checks++;
        if (!got || duty[W] !== exp_d) begin errors++; $display("FAIL pwm_duty64: got %0d want %0d", duty[W], exp_d); end
        repeat (300) @(negedge clk);
        highs = 0;
        for (int n = 0; n < 256; n++) begin
            if (pwm[W] === 1'b1) highs++;
            @(negedge clk);
        end
        checks++; if (highs != 64) begin errors++; $display("FAIL pwm_width64: got %0d want 64", highs); end
        $display("test_pwm: duty 64 high %0d of 256", highs);
        found = 1'b0;
        prev  = pwm[W];
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (!prev && pwm[W]) begin found = 1'b1; break; end
            prev = pwm[W];
        end
        checks++; if (!found) begin errors++; $display("FAIL pwm_align: no rising edge, want 1"); end
        t0 = tb_cyc;
        repeat (100) @(negedge clk);
        strobe(10'd128, 10'd0, 1'b1, 8'd128);
        wait_update(W, got);
        exp_d = exp_q.pop_front();
        checks++;
        if (!got || duty[W] !== exp_d) begin errors++; $display("FAIL pwm_duty128: got %0d want %0d", duty[W], exp_d); end
        found = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (pwm[W] === 1'b1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found || (tb_cyc - t0) != 256) begin
            errors++; $display("FAIL pwm_glitch_free: first high after %0d cycles want 256", tb_cyc - t0);
        end
        highs = 0;
        for (int n = 0; n < 400; n++) begin
            if (pwm[W] !== 1'b1) break;
            highs++;
            @(negedge clk);
        end
        checks++; if (highs != 128) begin errors++; $display("FAIL pwm_width128: got %0d want 128", highs); end
        $display("test_pwm: duty 128 high %0d", highs);
    endtask

    task automatic test_disable();
        bit got;
        bit found;
        bit saw_upd;
        logic [7:0] exp_d;
        do_reset();
        strobe(10'd300, 10'd100, 1'b1, 8'd200);
        wait_update(P, got);
        exp_d = exp_q.pop_front();
        checks++;
        if (!got || duty[P] !== exp_d) begin errors++; $display("FAIL disable_setup: got %0d want %0d", duty[P], exp_d); end
        found = 1'b0;
        for (int n = 0; n < 12000; n++) begin
            if (pwm[P] === 1'b1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL disable_pwm_high: pwm never high, want 1"); end
        strobe(10'd900, 10'd100, 1'b0, 8'd0);
        repeat (2) @(negedge clk);
        checks++; if (pwm[P] !== 1'b1) begin errors++; $display("FAIL disable_pre_pwm: got %b want 1", pwm[P]); end
        en = 1'b0;
        #1;
        checks++; if (pwm[P] !== 1'b0) begin errors++; $display("FAIL disable_pwm_low: got %b want 0", pwm[P]); end
        saw_upd = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (upd[P] === 1'b1) saw_upd = 1'b1;
        end
        checks++; if (saw_upd) begin errors++; $display("FAIL disable_no_update: got 1 want 0"); end
        checks++; if (duty[P] !== 8'd0) begin errors++; $display("FAIL disable_duty: got %0d want 0", duty[P]); end
        checks++; if (busy[P] !== 1'b0) begin errors++; $display("FAIL disable_busy: got %b want 0", busy[P]); end
        en = 1'b1;
        $display("test_disable: duty %0d pwm %b", duty[P], pwm[P]);
    endtask

    task automatic test_reset_midrun();
        bit got;
        bit saw_upd;
        logic [7:0] exp_d;
        do_reset();
        strobe(10'd300, 10'd100, 1'b1, 8'd200);
        wait_update(P, got);
        exp_d = exp_q.pop_front();
        checks++;
        if (!got || duty[P] !== exp_d) begin errors++; $display("FAIL midrun_setup: got %0d want %0d", duty[P], exp_d); end
        strobe(10'd900, 10'd100, 1'b0, 8'd0);
        @(negedge clk);
        checks++; if (busy[P] !== 1'b1) begin errors++; $display("FAIL midrun_busy_pre: got %b want 1", busy[P]); end
        #2 rst = 1'b1;
        #1;
        checks++; if (duty[P] !== 8'd0) begin errors++; $display("FAIL midrun_duty: got %0d want 0", duty[P]); end
        checks++; if (busy[P] !== 1'b0) begin errors++; $display("FAIL midrun_busy: got %b want 0", busy[P]); end
        checks++; if (pwm[P]  !== 1'b0) begin errors++; $display("FAIL midrun_pwm: got %b want 0", pwm[P]); end
        @(negedge clk);
        rst = 1'b0;
        saw_upd = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (upd[P] === 1'b1) saw_upd = 1'b1;
        end
        checks++; if (saw_upd) begin errors++; $display("FAIL midrun_no_update: got 1 want 0"); end
        $display("test_reset_midrun: duty %0d busy %b", duty[P], busy[P]);
    endtask

    initial begin
        rst   = 1'b0;
        en    = 1'b0;
        valid = 1'b0;
        tgt   = '0;
        act   = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_integral();
        test_derivative();
        test_pwm();
        test_disable();
        test_reset_midrun();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
